// File: rtl/jtopl_pm_if.sv
// Slot-stream bus between the channel register file and the JTOPL vibrato sequencer.
// Debug LFO load lines exist only when JTOPL_PM_DBG_EN is defined.
interface jtopl_pm_if #(
    parameter int FW    = 10,
    parameter int RB    = 3,
    parameter int SLOTS = 18
);
    localparam int SW = $clog2(SLOTS);

    logic          cen;
    logic          zero;
    logic [FW-1:0] fnum;
    logic          vib_dep;
    logic          viben;
    logic [RB:0]   pm_offset;
    logic [SW-1:0] slot_out;
    logic [2:0]    vib_cnt;
`ifdef JTOPL_PM_DBG_EN
    logic          dbg_load;
    logic [2:0]    dbg_cnt;

    modport master (
        output cen, zero, fnum, vib_dep, viben, dbg_load, dbg_cnt,
        input  pm_offset, slot_out, vib_cnt
    );
    modport slave (
        input  cen, zero, fnum, vib_dep, viben, dbg_load, dbg_cnt,
        output pm_offset, slot_out, vib_cnt
    );
`else
    modport master (
        output cen, zero, fnum, vib_dep, viben,
        input  pm_offset, slot_out, vib_cnt
    );
    modport slave (
        input  cen, zero, fnum, vib_dep, viben,
        output pm_offset, slot_out, vib_cnt
    );
`endif
endinterface

// File: rtl/jtopl_pm_seq.sv
// JTOPL vibrato sequencer: free-running LFO step counter plus a registered per-slot PM offset.
// Define JTOPL_PM_DBG_EN to add the dbg_load/dbg_cnt LFO preload.
module jtopl_pm_seq #(
    parameter int FW     = 10,
    parameter int RB     = 3,
    parameter int SLOTS  = 18,
    parameter int VIBDIV = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    jtopl_pm_if.slave bus
);
    localparam int SW = $clog2(SLOTS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    logic [VIBDIV-1:0]  smp_cnt;
    logic [2:0]         vib_cnt;
    logic [SW-1:0]      slot_cnt;
    logic signed [RB:0] pm_p1;
    logic [SW-1:0]      slot_p1;

    logic               adv_p0;
    logic               smp_wrap_p0;
    logic [VIBDIV-1:0]  smp_p0;
    logic [2:0]         vib_p0;
    logic [SW-1:0]      slot_p0;

    // Step 0 and 4 give no deviation; odd steps use half the range value.
    function automatic logic signed [RB:0] pm_calc(
        input logic [RB-1:0] hi,
        input logic [2:0]    v,
        input logic          dep,
        input logic          en
    );
        logic [RB-1:0]      r;
        logic signed [RB:0] mag;
        r = hi >> v[0];
        if (!dep) r = r >> 1;
        if (v[1:0] == 2'd0 || !en) r = '0;
        mag = signed'({1'b0, r});
        return v[2] ? -mag : mag;
    endfunction

    // Stage p0: counter next-state, with the LFO step forwarded to the zero slot
    always_comb begin
        adv_p0      = bus.cen & bus.zero;
        smp_wrap_p0 = adv_p0 && (smp_cnt == '1);
        smp_p0      = adv_p0 ? smp_cnt + 1'b1 : smp_cnt;
        vib_p0      = smp_wrap_p0 ? vib_cnt + 3'd1 : vib_cnt;
`ifdef JTOPL_PM_DBG_EN
        if (bus.cen && bus.dbg_load) begin
            vib_p0 = bus.dbg_cnt;
            smp_p0 = '0;
        end
`endif
        slot_p0 = bus.zero ? '0 : slot_cnt;
    end

    // Stage p1: registered offset and the slot it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt  <= '0;
            vib_cnt  <= '0;
            slot_cnt <= '0;
            pm_p1    <= '0;
            slot_p1  <= '0;
        end else if (bus.cen) begin
            smp_cnt  <= smp_p0;
            vib_cnt  <= vib_p0;
            slot_cnt <= (slot_p0 == LAST_SLOT) ? '0 : slot_p0 + 1'b1;
            pm_p1    <= pm_calc(bus.fnum[FW-1:FW-RB], vib_p0, bus.vib_dep, bus.viben);
            slot_p1  <= slot_p0;
        end
    end

    assign bus.pm_offset = pm_p1;
    assign bus.slot_out  = slot_p1;
    assign bus.vib_cnt   = vib_cnt;
endmodule

// File: tb/tb_jtopl_pm_seq.sv
// Directed bench for jtopl_pm_seq: vector table for PM values plus LFO, slot and reset sequences.
`timescale 1ns/1ps
module tb_jtopl_pm_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    jtopl_pm_if bus ();

    jtopl_pm_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0] v;
        logic [9:0] fnum;
        logic       dep;
        logic       en;
        logic [3:0] pm;
    } vec_t;

    vec_t vecs [21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zeros(input int n);
        bus.cen  = 1'b1;
        bus.zero = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus.cen  = 1'b0;
        bus.zero = 1'b0;
    endtask

    task automatic goto_v(input logic [2:0] v);
        int n;
        n = 0;
        bus.cen  = 1'b1;
        bus.zero = 1'b1;
        while (bus.vib_cnt !== v && n < 9000) begin
            tick();
            n++;
        end
        bus.cen  = 1'b0;
        bus.zero = 1'b0;
        if (bus.vib_cnt !== v) check("goto_v_timeout", 32'(bus.vib_cnt), 32'(v));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'd0, 10'h380, 1'b1, 1'b1, 4'h0};
        vecs[1]  = '{3'd1, 10'h380, 1'b1, 1'b1, 4'h3};
        vecs[2]  = '{3'd2, 10'h380, 1'b1, 1'b1, 4'h7};
        vecs[3]  = '{3'd3, 10'h380, 1'b1, 1'b1, 4'h3};
        vecs[4]  = '{3'd4, 10'h380, 1'b1, 1'b1, 4'h0};
        vecs[5]  = '{3'd5, 10'h380, 1'b1, 1'b1, 4'hD};
        vecs[6]  = '{3'd6, 10'h380, 1'b1, 1'b1, 4'h9};
        vecs[7]  = '{3'd7, 10'h380, 1'b1, 1'b1, 4'hD};
        vecs[8]  = '{3'd0, 10'h380, 1'b0, 1'b1, 4'h0};
        vecs[9]  = '{3'd1, 10'h380, 1'b0, 1'b1, 4'h1};
        vecs[10] = '{3'd2, 10'h380, 1'b0, 1'b1, 4'h3};
        vecs[11] = '{3'd3, 10'h380, 1'b0, 1'b1, 4'h1};
        vecs[12] = '{3'd4, 10'h380, 1'b0, 1'b1, 4'h0};
        vecs[13] = '{3'd5, 10'h380, 1'b0, 1'b1, 4'hF};
        vecs[14] = '{3'd6, 10'h380, 1'b0, 1'b1, 4'hD};
        vecs[15] = '{3'd7, 10'h380, 1'b0, 1'b1, 4'hF};
        vecs[16] = '{3'd1, 10'h1FF, 1'b1, 1'b1, 4'h1};
        vecs[17] = '{3'd2, 10'h3FF, 1'b1, 1'b0, 4'h0};
        vecs[18] = '{3'd2, 10'h3FF, 1'b1, 1'b1, 4'h7};
        vecs[19] = '{3'd6, 10'h2AB, 1'b1, 1'b1, 4'hB};
        vecs[20] = '{3'd7, 10'h2AB, 1'b0, 1'b1, 4'hF};

        bus.cen     = 1'b0;
        bus.zero    = 1'b0;
        bus.fnum    = 10'h3FF;
        bus.vib_dep = 1'b1;
        bus.viben   = 1'b1;
`ifdef JTOPL_PM_DBG_EN
        bus.dbg_load = 1'b0;
        bus.dbg_cnt  = 3'd0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_pm", 32'(bus.pm_offset), 32'h0);
        check("rst_slot", 32'(bus.slot_out), 32'h0);
        check("rst_vib", 32'(bus.vib_cnt), 32'h0);

        // zero without cen must be ignored
        bus.zero = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        bus.zero = 1'b0;
        check("idle_pm", 32'(bus.pm_offset), 32'h0);
        check("idle_slot", 32'(bus.slot_out), 32'h0);
        check("idle_vib", 32'(bus.vib_cnt), 32'h0);

        bus.cen = 1'b1;
        tick();
        bus.cen = 1'b0;
        check("first_slot", 32'(bus.slot_out), 32'h0);

        // 1024 full frames: the step lands on the 1024th zero
        for (int f = 0; f < 1024; f++) begin
            for (int s = 0; s < 18; s++) begin
                bus.cen  = 1'b1;
                bus.zero = (s == 0);
                tick();
                if (f == 0) check($sformatf("slot%0d", s), 32'(bus.slot_out), 32'(s));
                if (f == 1022 && s == 17) check("vib_before_1024", 32'(bus.vib_cnt), 32'h0);
                if (f == 1023 && s == 0) check("vib_at_1024", 32'(bus.vib_cnt), 32'h1);
            end
        end
        bus.zero = 1'b0;
        tick();
        bus.cen = 1'b0;
        check("slot_wrap", 32'(bus.slot_out), 32'h0);

        zeros(7167);
        check("vib_8191", 32'(bus.vib_cnt), 32'h7);
        zeros(1);
        check("vib_8192", 32'(bus.vib_cnt), 32'h0);

        for (int i = 0; i < 21; i++) begin
            goto_v(vecs[i].v);
            bus.fnum    = vecs[i].fnum;
            bus.vib_dep = vecs[i].dep;
            bus.viben   = vecs[i].en;
            bus.cen     = 1'b1;
            bus.zero    = 1'b0;
            tick();
            bus.cen = 1'b0;
            check($sformatf("vec%0d_pm", i), 32'(bus.pm_offset), 32'(vecs[i].pm));
        end

        // zero slot on the wrap cycle must see the new step (2 -> 7, not 1 -> 3)
        goto_v(3'd1);
        zeros(1023);
        bus.fnum    = 10'h380;
        bus.vib_dep = 1'b1;
        bus.viben   = 1'b1;
        zeros(1);
        check("fwd_pm", 32'(bus.pm_offset), 32'h7);
        check("fwd_vib", 32'(bus.vib_cnt), 32'h2);

        bus.fnum  = 10'h000;
        bus.viben = 1'b0;
        bus.zero  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.zero = 1'b0;
        check("hold_pm", 32'(bus.pm_offset), 32'h7);
        check("hold_slot", 32'(bus.slot_out), 32'h0);

        // asynchronous reset in the middle of a frame
        goto_v(3'd5);
        bus.fnum  = 10'h380;
        bus.viben = 1'b1;
        for (int s = 0; s < 10; s++) begin
            bus.cen  = 1'b1;
            bus.zero = (s == 0);
            tick();
        end
        bus.cen  = 1'b0;
        bus.zero = 1'b0;
        check("pre_rst_pm", 32'(bus.pm_offset), 32'hD);
        check("pre_rst_slot", 32'(bus.slot_out), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pm", 32'(bus.pm_offset), 32'h0);
        check("mid_rst_slot", 32'(bus.slot_out), 32'h0);
        check("mid_rst_vib", 32'(bus.vib_cnt), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.cen  = 1'b1;
        bus.zero = 1'b1;
        tick();
        check("restart_pm0", 32'(bus.pm_offset), 32'h0);
        check("restart_vib", 32'(bus.vib_cnt), 32'h0);
        bus.zero = 1'b0;
        tick();
        bus.cen = 1'b0;
        check("restart_slot1", 32'(bus.slot_out), 32'h1);
        check("restart_pm1", 32'(bus.pm_offset), 32'h0);

`ifdef JTOPL_PM_DBG_EN
        zeros(1022);
        check("dbg_pre_vib", 32'(bus.vib_cnt), 32'h0);
        bus.dbg_load = 1'b1;
        bus.dbg_cnt  = 3'd6;
        zeros(1);
        bus.dbg_load = 1'b0;
        check("dbg_vib", 32'(bus.vib_cnt), 32'h6);
        check("dbg_pm", 32'(bus.pm_offset), 32'h9);
        zeros(1023);
        check("dbg_hold_vib", 32'(bus.vib_cnt), 32'h6);
        zeros(1);
        check("dbg_next_vib", 32'(bus.vib_cnt), 32'h7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jtopl_pm_seq.md
# jtopl_pm_seq

Sequenced vibrato (phase-modulation) unit for the JTOPL operator pipeline. Owns the vibrato LFO step counter and evaluates a registered per-slot PM offset for every slot on each clock enable. Replaces the purely combinational PM calculation and adds a generic f-number width, range resolution, slot count and LFO rate. Sits between the channel register file and the phase generator, one slot per `cen`.

## Interface
- `FW`, 10: f-number width.
- `RB`, 3: range bits taken from `fnum[FW-1:FW-RB]`; output width is RB+1.
- `SLOTS`, 18: slots per sample frame.
- `VIBDIV`, 10: log2 of samples per vibrato step.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cen` in 1: clock enable, one slot per enabled cycle.
- `zero` in 1: marks slot 0 of a sample frame; sampled only when `cen`=1.
- `fnum` in FW: current slot f-number.
- `vib_dep` in 1: 1 = full depth, 0 = half depth.
- `viben` in 1: vibrato enable for current slot.
- `pm_offset` out RB+1: two's-complement PM offset, registered.
- `slot_out` out $clog2(SLOTS): slot index aligned with `pm_offset`.
- `vib_cnt` out 3: current LFO step.
- `dbg_load` in 1, `dbg_cnt` in 3: present only with `JTOPL_PM_DBG_EN`.

## Operation
- State: `smp_cnt` (VIBDIV bits), `vib_cnt` (3 bits), `slot_cnt`, output registers. Nothing changes when `cen`=0.
- Sample counter: on `cen & zero`, `smp_cnt` += 1, wrapping at 2^VIBDIV. When it wraps to 0, `vib_cnt` += 1 (7 wraps to 0).
- Slot counter: on `cen`, if `zero` then 0, else +1. Reaching SLOTS-1 without `zero` wraps to 0.
- Forwarding: the slot presented with `zero` uses the updated `vib_cnt`, so every slot of a frame sees one value.
- Per-slot arithmetic, with v = effective `vib_cnt`:
  - If v[1:0]=0, r = 0.
  - Otherwise r = `fnum[FW-1:FW-RB]` >> v[0], then shifted >> 1 more if `vib_dep`=0.
  - Result = {0,r}, two's-negated to RB+1 bits if v[2].
  - `viben`=0 forces the result to 0.
- Sequence with RB=3, `vib_dep`=1, r7=7: v0..7 give 0, +3, +7, +3, 0, -3, -7, -3.
- On `cen`, `pm_offset` takes the result and `slot_out` takes the slot index used for that input.

## Timing
- Reset: `pm_offset`=0, `slot_out`=0, `vib_cnt`=0, `smp_cnt`=0, `slot_cnt`=0. Reset takes effect immediately and asynchronously, including mid-frame; the first `cen` after release treats the slot as slot 0 unless `zero` says otherwise.
- Latency: one enabled cycle from `fnum`/`viben` to `pm_offset`. Outputs are stable between enables.
- `zero` with `cen`=0 is ignored.
- `vib_cnt` output changes in the same edge as the `smp_cnt` wrap.
- No handshake; the upstream must present one slot per `cen`.

## Configuration
- `JTOPL_PM_DBG_EN` defined: adds `dbg_load`/`dbg_cnt`. On `cen & dbg_load`, `vib_cnt` <= `dbg_cnt` and `smp_cnt` <= 0. This has priority over a simultaneous wrap increment, and the forwarded value for that slot is `dbg_cnt`.
- Undefined: ports absent and the LFO is free-running only.

## Test plan
- Reset, then no `cen` for 100 cycles -> all outputs 0, counters frozen.
- 1024 frames of 18 slots with `zero` on slot 0 -> `vib_cnt` steps 0->1 exactly on the 1024th `zero`. After 8192 frames it is back to 0.
- `fnum`=0x380, `vib_dep`=1, `viben`=1 swept over v=0..7 -> `pm_offset` 0,3,7,3,0,0xD,0x9,0xD, each one `cen` after input. Repeat with `vib_dep`=0 -> 0,1,3,1,0,0xF,0xD,0xF.
- `viben`=0 at v=2, `fnum`=0x3FF -> `pm_offset`=0. `slot_out` tracks 0..17, and a missing `zero` wraps it to 0 after 17.
- Assert `rst_n` low mid-frame at slot 9 with `vib_cnt`=5 -> outputs 0 immediately. Restart gives v=0 results.
- With `JTOPL_PM_DBG_EN`: `dbg_load`, `dbg_cnt`=6 on a wrap cycle -> `vib_cnt`=6, that slot gives -7, and the next step occurs 1024 frames later.
